// File: rtl/gate_tt_bist_if.sv
// gate_tt_bist_if: control, result and gate-side signals of the truth-table BIST
interface gate_tt_bist_if #(
  parameter int N_IN = 2
);
  logic start;
  logic dut_out;
  logic busy;
  logic done;
  logic pass;
  logic [N_IN-1:0] dut_in;
  logic [N_IN:0] err_count;
  logic [(1<<N_IN)-1:0] fail_vec;
  modport master (output start, dut_out, input dut_in, busy, done, pass, err_count, fail_vec);
  modport slave (input start, dut_out, output dut_in, busy, done, pass, err_count, fail_vec);
endinterface

// File: rtl/gate_tt_bist.sv
// gate_tt_bist: sweeps every gate input vector, samples after a settle interval and tallies truth-table mismatches
module gate_tt_bist #(
  parameter int N_IN = 2,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] TT = 4'b1000
) (
  input logic clk,
  input logic rst_n,
  gate_tt_bist_if.slave b
);
  localparam int NV = 1 << N_IN;
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, SET, SAMP, DONE} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N_IN-1:0] vin, vin_n;
  logic [N_IN:0] ec, ec_n;
  logic [NV-1:0] fv, fv_n;
  logic busy_r, busy_n, done_r, done_n;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    vin_n = vin;
    ec_n = ec;
    fv_n = fv;
    busy_n = busy_r;
    done_n = done_r;
    case (st)
      IDLE, DONE: if (b.start) begin
        st_n = SET;
        vin_n = '0;
        cnt_n = CW'(SETTLE);
        ec_n = '0;
        fv_n = '0;
        busy_n = 1'b1;
        done_n = 1'b0;
      end
      SET: begin
        cnt_n = cnt - CW'(1);
        st_n = cnt == CW'(1) ? SAMP : SET;
      end
      SAMP: begin
        if (b.dut_out != TT[vin]) begin
          ec_n = ec + (N_IN+1)'(1);
          fv_n[vin] = 1'b1;
        end
        if (vin == '1) begin
          st_n = DONE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end else begin
          st_n = SET;
          vin_n = vin + N_IN'(1);
          cnt_n = CW'(SETTLE);
        end
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      vin <= '0;
      ec <= '0;
      fv <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      vin <= vin_n;
      ec <= ec_n;
      fv <= fv_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  assign b.dut_in = vin;
  assign b.busy = busy_r;
  assign b.done = done_r;
  assign b.err_count = ec;
  assign b.fail_vec = fv;
  assign b.pass = done_r && ec == '0;
endmodule
